// File: rtl/multicycle_adder_flags.sv
// Chunk-serial add/subtract with ALU flags: CHUNK bits per clock, start/busy/done handshake.
// Optional saturation on signed overflow is built when ADDER_SATURATE_EN is defined.
module multicycle_adder_flags #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Overflow,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   partial_q, partial_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               ovf_q, ovf_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    int unsigned        idx;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_p;
    logic               chunk_c;
    logic               c_msb_in;
    logic               raw_ovf;
    logic [WIDTH-1:0]   sum_full;

    // Ripple through the active chunk; the carry entering its top bit is kept so
    // the last chunk yields the carry into the operand MSB for overflow.
    always_comb begin : chunk_adder
        logic c;
        idx      = 32'(cnt_q) * CHUNK;
        chunk_a  = opa_q[idx +: CHUNK];
        chunk_b  = opb_q[idx +: CHUNK];
        chunk_p  = '0;
        c        = carry_q;
        c_msb_in = carry_q;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            chunk_p[j] = chunk_a[j] ^ chunk_b[j] ^ c;
            if (j == CHUNK - 1) begin
                c_msb_in = c;
            end
            c = (chunk_a[j] & chunk_b[j]) | (c & (chunk_a[j] ^ chunk_b[j]));
        end
        chunk_c = c;
    end

    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        carry_d   = carry_q;
        partial_d = partial_q;
        s_d       = s_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        raw_ovf   = 1'b0;
        sum_full  = partial_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d     = A;
                    opb_d     = sub ? ~B : B;
                    carry_d   = sub;
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                partial_d[idx +: CHUNK] = chunk_p;
                carry_d                 = chunk_c;
                cnt_d                   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    sum_full = partial_d;
                    raw_ovf  = c_msb_in ^ chunk_c;
                    s_d      = sum_full;
`ifdef ADDER_SATURATE_EN
                    if (raw_ovf) begin
                        s_d = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    ovf_d   = raw_ovf;
                    cout_d  = chunk_c;
                    zero_d  = (s_d == '0);
                    neg_d   = s_d[WIDTH-1];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            carry_q   <= 1'b0;
            partial_q <= '0;
            s_q       <= '0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            carry_q   <= carry_d;
            partial_q <= partial_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign S        = s_q;
    assign Overflow = ovf_q;
    assign Carry    = cout_q;
    assign Zero     = zero_q;
    assign Negative = neg_q;

endmodule

// File: tb/tb_multicycle_adder_flags.sv
// Bench for multicycle_adder_flags (WIDTH=16, CHUNK=4) against an integer-arithmetic model.
module tb_multicycle_adder_flags;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        Overflow;
    logic        Carry;
    logic        Zero;
    logic        Negative;

    int          tests;
    int          fails;
    logic [15:0] prev_s;

    multicycle_adder_flags #(.WIDTH(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .S        (S),
        .Overflow (Overflow),
        .Carry    (Carry),
        .Zero     (Zero),
        .Negative (Negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carry, zero, negative, sum} from signed/unsigned integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int          sa;
        int          sb;
        int          r;
        logic        o;
        logic        c;
        logic [15:0] res;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = s ? (sa - sb) : (sa + sb);
        o   = (r > 32767) || (r < -32768);
        c   = s ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 65535);
        res = r[15:0];
`ifdef ADDER_SATURATE_EN
        if (o) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {o, c, (res == 16'h0000), res[15], res};
    endfunction

    // Issue one operation and check latency, hold of the previous result and the final flags.
    // With poke set, a second start with different operands is raised while busy.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input bit poke);
        int          cyc;
        bit          got;
        logic [19:0] m;
        cyc = 0;
        while (busy && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("idle_before_start", 32'(busy), 32'd0);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("s_hold_while_busy", 32'(S), 32'(prev_s));
            end
            if (poke && cyc == 1) begin
                start = 1'b1; A = ~a; B = a ^ b; sub = ~s;
            end
            if (poke && cyc == 2) start = 1'b0;
        end
        m = model(a, b, s);
        chk("latency", 32'(cyc), 32'd4);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum", 32'(S), 32'(m[15:0]));
        chk("overflow", 32'(Overflow), 32'(m[19]));
        chk("carry", 32'(Carry), 32'(m[18]));
        chk("zero", 32'(Zero), 32'(m[17]));
        chk("negative", 32'(Negative), 32'(m[16]));
        prev_s = m[15:0];
    endtask

    logic [15:0] da [6];
    logic [15:0] db [6];
    logic        ds [6];

    initial begin
        tests = 0; fails = 0; prev_s = 16'h0000;
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        da[0] = 16'h0001; db[0] = 16'h0001; ds[0] = 1'b0;
        da[1] = 16'h7FFF; db[1] = 16'h0001; ds[1] = 1'b0;
        da[2] = 16'hFFFF; db[2] = 16'h0001; ds[2] = 1'b0;
        da[3] = 16'h8030; db[3] = 16'h80E0; ds[3] = 1'b0;
        da[4] = 16'h8000; db[4] = 16'h0001; ds[4] = 1'b1;
        da[5] = 16'h0000; db[5] = 16'h0001; ds[5] = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s", 32'(S), 32'd0);
        chk("reset_flags", {28'd0, Overflow, Carry, Zero, Negative}, 32'd0);

        // Directed cases with idle gaps
        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], ds[i], 1'b0);
            @(posedge clk); #1;
        end
        chk("spec_case1_sum", 32'(model(16'h0001, 16'h0001, 1'b0)), 32'h00002);

        // Start while busy is ignored
        run_op(16'h1234, 16'h1111, 1'b0, 1'b1);

        // Result and flags hold after done with no new start
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_s_idle", 32'(S), 32'(prev_s));
            chk("hold_done_low", 32'(done), 32'd0);
            chk("hold_busy_low", 32'(busy), 32'd0);
        end

        // Reset in the middle of a run aborts it
        A = 16'h7FFF; B = 16'h7FFF; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(S), 32'd0);
        chk("abort_flags", {28'd0, Overflow, Carry, Zero, Negative}, 32'd0);
        prev_s = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Back-to-back: second start in the done cycle of the first
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        run_op(16'h0400, 16'h8000, 1'b0, 1'b0);

        // Random operations with random gaps, including back-to-back
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
